// File: rtl/multi_access_counter_pkg.sv
// Shared constants for the multi-channel access counter: overflow mode
// encodings and the select-width helper.
package multi_access_counter_pkg;

  localparam int SAT_MODE  = 1;
  localparam int WRAP_MODE = 0;

  function automatic int clog2(input int n);
    int r;
    r = 0;
    for (int i = 0; i < 32; i++) begin
      if ((1 << r) < n) r = r + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/access_counter_chan.sv
// One counter channel: synchronised event input, counter with wrap or
// saturate, sticky overflow and threshold flags, snapshot shadow register.
module access_counter_chan
  import multi_access_counter_pkg::*;
#(
  parameter int WIDTH    = 10,
  parameter int SATURATE = WRAP_MODE
) (
  input  logic             clk,
  input  logic             nrst,
  input  logic             count_ena,
  input  logic             clear,
  input  logic             snap,
  input  logic             snap_clr,
  input  logic [WIDTH-1:0] threshold,
  input  logic             irq_ack,
  output logic [WIDTH-1:0] shadow,
  output logic             ovf,
  output logic             irq
);

  localparam logic [WIDTH-1:0] ALL_ONES = '1;

  logic             inc;
  logic [WIDTH-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] shadow_q, shadow_d;
  logic             ovf_q, ovf_d;
  logic             irq_q, irq_d;
  logic             at_max, sat_hold, snap_zero, advanced;

  pulse_sync u_sync (
    .clk   (clk),
    .nrst  (nrst),
    .din   (count_ena),
    .pulse (inc)
  );

  always_comb begin
    cnt_d     = cnt_q;
    shadow_d  = shadow_q;
    ovf_d     = ovf_q;
    irq_d     = irq_q;
    at_max    = (cnt_q == ALL_ONES);
    sat_hold  = inc && at_max && (SATURATE == SAT_MODE);
    snap_zero = snap && snap_clr;
    // a snap-clear restarts from zero, so the increment always lands
    advanced  = inc && (snap_zero || !sat_hold);

    if (snap) shadow_d = cnt_q;

    if (clear) begin
      cnt_d = '0;
      ovf_d = 1'b0;
      irq_d = 1'b0;
    end else begin
      if (snap_zero)               cnt_d = inc ? WIDTH'(1) : '0;
      else if (inc && !sat_hold)   cnt_d = cnt_q + WIDTH'(1);
      if (inc && at_max)           ovf_d = 1'b1;
      if (irq_ack)                 irq_d = 1'b0;
      if (advanced && (cnt_d == threshold) && (threshold != '0))
        irq_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      cnt_q    <= '0;
      shadow_q <= '0;
      ovf_q    <= 1'b0;
      irq_q    <= 1'b0;
    end else begin
      cnt_q    <= cnt_d;
      shadow_q <= shadow_d;
      ovf_q    <= ovf_d;
      irq_q    <= irq_d;
    end
  end

  assign shadow = shadow_q;
  assign ovf    = ovf_q;
  assign irq    = irq_q;

endmodule

// File: rtl/pulse_sync.sv
// Two-flop synchroniser plus edge flop; emits a one-cycle pulse per rising
// edge of the synchronised input.
module pulse_sync (
  input  logic clk,
  input  logic nrst,
  input  logic din,
  output logic pulse
);

  // [0],[1] synchroniser, [2] edge-detect history
  logic [2:0] sync_q, sync_d;
  logic [1:0] arm_q, arm_d;
  logic       armed;

  // Edge detection stays blind until the chain has refilled after reset,
  // so a level already high at deassertion is not mistaken for an edge.
  assign armed = (arm_q == 2'd3);

  always_comb begin
    sync_d = {sync_q[1:0], din};
    arm_d  = armed ? arm_q : arm_q + 2'd1;
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      sync_q <= '0;
      arm_q  <= '0;
    end else begin
      sync_q <= sync_d;
      arm_q  <= arm_d;
    end
  end

  assign pulse = sync_q[1] & ~sync_q[2] & armed;

endmodule

// File: rtl/multi_access_counter.sv
// NCH independent access counters with coherent snapshot and a registered
// channel-select readout of the shadow registers.
module multi_access_counter
  import multi_access_counter_pkg::*;
#(
  parameter int WIDTH    = 10,
  parameter int NCH      = 4,
  parameter int SATURATE = WRAP_MODE,
  parameter int SELW     = 2
) (
  input  logic             clk,
  input  logic             nrst,
  input  logic [NCH-1:0]   count_ena,
  input  logic [NCH-1:0]   clear,
  input  logic             snap,
  input  logic             snap_clr,
  input  logic [WIDTH-1:0] threshold,
  input  logic [NCH-1:0]   irq_ack,
  input  logic [SELW-1:0]  rd_sel,
  output logic [WIDTH-1:0] rd_count,
  output logic [NCH-1:0]   ovf,
  output logic [NCH-1:0]   irq
);

  if (SELW < clog2(NCH)) begin : g_bad_selw
    $error("rd_sel too narrow for channel count");
  end

  logic [NCH-1:0][WIDTH-1:0] shadow;
  logic [WIDTH-1:0]          rd_count_q, rd_count_d;

  for (genvar i = 0; i < NCH; i++) begin : g_chan
    access_counter_chan #(
      .WIDTH    (WIDTH),
      .SATURATE (SATURATE)
    ) u_chan (
      .clk       (clk),
      .nrst      (nrst),
      .count_ena (count_ena[i]),
      .clear     (clear[i]),
      .snap      (snap),
      .snap_clr  (snap_clr),
      .threshold (threshold),
      .irq_ack   (irq_ack[i]),
      .shadow    (shadow[i]),
      .ovf       (ovf[i]),
      .irq       (irq[i])
    );
  end

  // select values past the last channel fall through to zero
  always_comb begin
    rd_count_d = '0;
    for (int i = 0; i < NCH; i++) begin
      if (rd_sel == SELW'(i)) rd_count_d = shadow[i];
    end
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) rd_count_q <= '0;
    else       rd_count_q <= rd_count_d;
  end

  assign rd_count = rd_count_q;

endmodule

// File: tb/tb_multi_access_counter.sv
// Directed bench: default wrap counter, narrow wrap (3 channels) and narrow
// saturating counter, all driven from shared stimulus.
module tb_multi_access_counter;

  logic       clk = 1'b0;
  logic       nrst;
  logic [3:0] count_ena, clear, irq_ack;
  logic       snap, snap_clr;
  logic [9:0] thr10;
  logic [3:0] thr4;
  logic [1:0] rd_sel;
  logic [9:0] rd_d;
  logic [3:0] rd_w, rd_s;
  logic [3:0] ovf_d, irq_d, ovf_s, irq_s;
  logic [2:0] ovf_w, irq_w;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  multi_access_counter #(.WIDTH(10), .NCH(4), .SATURATE(0), .SELW(2)) u_d (
    .clk(clk), .nrst(nrst), .count_ena(count_ena), .clear(clear), .snap(snap),
    .snap_clr(snap_clr), .threshold(thr10), .irq_ack(irq_ack), .rd_sel(rd_sel),
    .rd_count(rd_d), .ovf(ovf_d), .irq(irq_d));

  multi_access_counter #(.WIDTH(4), .NCH(3), .SATURATE(0), .SELW(2)) u_w (
    .clk(clk), .nrst(nrst), .count_ena(count_ena[2:0]), .clear(clear[2:0]),
    .snap(snap), .snap_clr(snap_clr), .threshold(thr4), .irq_ack(irq_ack[2:0]),
    .rd_sel(rd_sel), .rd_count(rd_w), .ovf(ovf_w), .irq(irq_w));

  multi_access_counter #(.WIDTH(4), .NCH(4), .SATURATE(1), .SELW(2)) u_s (
    .clk(clk), .nrst(nrst), .count_ena(count_ena), .clear(clear), .snap(snap),
    .snap_clr(snap_clr), .threshold(thr4), .irq_ack(irq_ack), .rd_sel(rd_sel),
    .rd_count(rd_s), .ovf(ovf_s), .irq(irq_s));

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // one event: 3 cycles high, 2 low
  task automatic pulse(input int ch, input int n);
    repeat (n) begin
      count_ena[ch] = 1'b1;
      repeat (3) tick();
      count_ena[ch] = 1'b0;
      repeat (2) tick();
    end
  endtask

  // snapshot without clearing, then read the selected shadow of each DUT
  task automatic read(input int ch, output logic [9:0] d, output logic [3:0] w,
                      output logic [3:0] s);
    snap = 1'b1;
    tick();
    snap   = 1'b0;
    rd_sel = 2'(ch);
    tick();
    d = rd_d;
    w = rd_w;
    s = rd_s;
  endtask

  task automatic clear_all();
    clear = 4'hF;
    tick();
    clear = 4'h0;
    tick();
  endtask

  task automatic test_reset();
    nrst = 1'b0; count_ena = '0; clear = '0; irq_ack = '0;
    snap = 1'b0; snap_clr = 1'b0; thr10 = '0; thr4 = '0; rd_sel = '0;
    repeat (3) tick();
    tests++; if (rd_d !== 10'd0) begin fails++; $display("FAIL reset_rd_d: got %0d want 0", rd_d); end
    tests++; if ({ovf_d, irq_d, ovf_s, irq_s} !== 16'h0) begin fails++; $display("FAIL reset_flags: got %h want 0", {ovf_d, irq_d, ovf_s, irq_s}); end
    tests++; if ({ovf_w, irq_w, rd_w, rd_s} !== 14'h0) begin fails++; $display("FAIL reset_narrow: got %h want 0", {ovf_w, irq_w, rd_w, rd_s}); end
    nrst = 1'b1;
    repeat (4) tick();
  endtask

  task automatic test_basic();
    logic [9:0] d; logic [3:0] w, s;
    pulse(0, 3);
    read(0, d, w, s);
    tests++; if (d !== 10'd3) begin fails++; $display("FAIL basic_ch0: got %0d want 3", d); end
    tests++; if (s !== 4'd3) begin fails++; $display("FAIL basic_ch0_sat: got %0d want 3", s); end
    read(1, d, w, s);
    tests++; if (d !== 10'd0) begin fails++; $display("FAIL basic_ch1: got %0d want 0", d); end
    tests++; if ({ovf_d, irq_d} !== 8'h0) begin fails++; $display("FAIL basic_flags: got %h want 0", {ovf_d, irq_d}); end
    clear_all();
  endtask

  task automatic test_wrap();
    logic [9:0] d; logic [3:0] w, s;
    pulse(1, 15);
    tests++; if (ovf_w[1] !== 1'b0) begin fails++; $display("FAIL wrap_no_ovf15: got %b want 0", ovf_w[1]); end
    pulse(1, 1);
    tests++; if (ovf_w[1] !== 1'b1) begin fails++; $display("FAIL wrap_ovf16: got %b want 1", ovf_w[1]); end
    pulse(1, 1);
    read(1, d, w, s);
    tests++; if (w !== 4'd1) begin fails++; $display("FAIL wrap_count17: got %0d want 1", w); end
    tests++; if (s !== 4'd15) begin fails++; $display("FAIL sat_count17: got %0d want 15", s); end
    tests++; if (d !== 10'd17) begin fails++; $display("FAIL wide_count17: got %0d want 17", d); end
    tests++; if (ovf_d[1] !== 1'b0) begin fails++; $display("FAIL wide_no_ovf: got %b want 0", ovf_d[1]); end
    clear[1] = 1'b1; tick(); clear[1] = 1'b0;
    tests++; if (ovf_w[1] !== 1'b0) begin fails++; $display("FAIL wrap_ovf_clear: got %b want 0", ovf_w[1]); end
    read(1, d, w, s);
    tests++; if (w !== 4'd0) begin fails++; $display("FAIL wrap_count_clear: got %0d want 0", w); end
    clear_all();
  endtask

  task automatic test_saturate();
    logic [9:0] d; logic [3:0] w, s;
    thr4 = 4'd15;
    pulse(2, 14);
    tests++; if (irq_s[2] !== 1'b0) begin fails++; $display("FAIL sat_irq14: got %b want 0", irq_s[2]); end
    pulse(2, 1);
    tests++; if (irq_s[2] !== 1'b1) begin fails++; $display("FAIL sat_irq15: got %b want 1", irq_s[2]); end
    irq_ack[2] = 1'b1; tick(); irq_ack[2] = 1'b0;
    tests++; if (irq_s[2] !== 1'b0) begin fails++; $display("FAIL sat_irq_ack: got %b want 0", irq_s[2]); end
    pulse(2, 5);
    tests++; if (irq_s[2] !== 1'b0) begin fails++; $display("FAIL sat_irq_no_retrig: got %b want 0", irq_s[2]); end
    tests++; if (ovf_s[2] !== 1'b1) begin fails++; $display("FAIL sat_ovf: got %b want 1", ovf_s[2]); end
    read(2, d, w, s);
    tests++; if (s !== 4'd15) begin fails++; $display("FAIL sat_count20: got %0d want 15", s); end
    tests++; if (w !== 4'd4) begin fails++; $display("FAIL wrap_count20: got %0d want 4", w); end
    thr4 = 4'd0;
    clear_all();
  endtask

  task automatic test_threshold();
    thr10 = 10'd5;
    pulse(0, 4);
    tests++; if (irq_d[0] !== 1'b0) begin fails++; $display("FAIL thr_irq4: got %b want 0", irq_d[0]); end
    count_ena[0] = 1'b1;
    tick(); tick();
    tests++; if (irq_d[0] !== 1'b0) begin fails++; $display("FAIL thr_irq_early: got %b want 0", irq_d[0]); end
    irq_ack[0] = 1'b1;
    tick();
    irq_ack[0] = 1'b0;
    tests++; if (irq_d[0] !== 1'b1) begin fails++; $display("FAIL thr_set_beats_ack: got %b want 1", irq_d[0]); end
    count_ena[0] = 1'b0;
    repeat (2) tick();
    irq_ack[0] = 1'b1; tick(); irq_ack[0] = 1'b0;
    tests++; if (irq_d[0] !== 1'b0) begin fails++; $display("FAIL thr_ack: got %b want 0", irq_d[0]); end
    thr10 = 10'd0;
    clear_all();
  endtask

  task automatic test_snap_clr();
    logic [9:0] d; logic [3:0] w, s;
    pulse(3, 7);
    count_ena[3] = 1'b1;
    tick(); tick();
    snap = 1'b1; snap_clr = 1'b1;
    tick();
    snap = 1'b0; snap_clr = 1'b0; rd_sel = 2'd3;
    tick();
    tests++; if (rd_d !== 10'd7) begin fails++; $display("FAIL snapclr_shadow: got %0d want 7", rd_d); end
    tests++; if (rd_s !== 4'd7) begin fails++; $display("FAIL snapclr_shadow_sat: got %0d want 7", rd_s); end
    tests++; if (rd_w !== 4'd0) begin fails++; $display("FAIL rd_sel_oob: got %0d want 0", rd_w); end
    count_ena[3] = 1'b0;
    tick();
    read(3, d, w, s);
    tests++; if (d !== 10'd1) begin fails++; $display("FAIL snapclr_live: got %0d want 1", d); end
    clear_all();
  endtask

  task automatic test_clear_reset();
    logic [9:0] d; logic [3:0] w, s;
    pulse(0, 2);
    count_ena[0] = 1'b1;
    tick(); tick();
    clear[0] = 1'b1;
    tick();
    clear[0] = 1'b0; count_ena[0] = 1'b0;
    repeat (2) tick();
    read(0, d, w, s);
    tests++; if (d !== 10'd0) begin fails++; $display("FAIL clear_drops_inc: got %0d want 0", d); end
    pulse(0, 2);
    read(0, d, w, s);
    tests++; if (d !== 10'd2) begin fails++; $display("FAIL pre_reset_count: got %0d want 2", d); end
    count_ena[0] = 1'b1;
    tick(); tick();
    nrst = 1'b0;
    #1;
    tests++; if (rd_d !== 10'd0) begin fails++; $display("FAIL async_reset_rd: got %0d want 0", rd_d); end
    tick();
    nrst = 1'b1;
    repeat (6) tick();
    read(0, d, w, s);
    tests++; if (d !== 10'd0) begin fails++; $display("FAIL held_ena_no_count: got %0d want 0", d); end
    count_ena[0] = 1'b0;
    repeat (2) tick();
    pulse(0, 1);
    read(0, d, w, s);
    tests++; if (d !== 10'd1) begin fails++; $display("FAIL post_reset_count: got %0d want 1", d); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_wrap();
    test_saturate();
    test_threshold();
    test_snap_clr();
    test_clear_reset();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

endmodule
